alu_sweep_driver: RTL and testbench

Sequential stimulus and capture engine for the 4-bit ALU (operands a, b; opcode; results x, y). On a start pulse it latches one operand pair and sweeps opcode 0..OP_COUNT-1. For each opcode it waits a settle time, captures x/y and streams them out with a valid strobe. It folds all results into an 8-bit signature and pulses done. It sits on the driving side of the ALU and replaces hand-written opcode loops with synthesizable on-chip self-test.

---
 rtl/alu_sweep_driver.sv | 106 ++++++++++
 tb/tb_alu_sweep_driver.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_driver.sv
// Drives an ALU through every opcode for one latched operand pair.
// Each result is captured, streamed out and folded into a rotate-XOR signature.
module alu_sweep_driver #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned OP_COUNT = 16,
  parameter int unsigned SETTLE   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 res_valid,
  output logic [3:0]           res_op,
  output logic [WIDTH-1:0]     res_x,
  output logic [WIDTH-1:0]     res_y,
  output logic [2*WIDTH-1:0]   signature,
  output logic                 done
);

  localparam int unsigned SIG_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [3:0]       LAST_OP     = 4'(OP_COUNT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Sweep sequencer; res_valid and done are single-cycle strobes cleared by default.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      opcode    <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_op    <= '0;
      res_x     <= '0;
      res_y     <= '0;
      signature <= '0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a         <= a_in;
            b         <= b_in;
            opcode    <= '0;
            signature <= '0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          res_x     <= x;
          res_y     <= y;
          res_op    <= opcode;
          res_valid <= 1'b1;
          signature <= {signature[SIG_W-2:0], signature[SIG_W-1]} ^ {x, y};
          if (opcode == LAST_OP) begin
            // done/busy are set on entry so they are visible during DONE itself
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            opcode <= opcode + 4'd1;
            cnt    <= '0;
            state  <= S_WAIT;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver: default build (dut0) and SETTLE=3/OP_COUNT=4 build (dut1).
// Values observed just after clock edge n correspond to cycle n+1 of the timing description.
module tb_alu_sweep_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start0, start1;
  logic [3:0] a_in0, b_in0, a_in1, b_in1;
  logic [3:0] x0, y0, x1, y1;
  logic [3:0] a0, b0, op0, res_op0, res_x0, res_y0;
  logic [3:0] a1, b1, op1, res_op1, res_x1, res_y1;
  logic       busy0, rv0, done0, busy1, rv1, done1;
  logic [7:0] sig0, sig1;

  // Stub ALUs: x follows the opcode, y is zero
  assign x0 = op0;
  assign y0 = 4'h0;
  assign x1 = op1;
  assign y1 = 4'h0;

  alu_sweep_driver dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a_in(a_in0), .b_in(b_in0),
    .a(a0), .b(b0), .opcode(op0), .x(x0), .y(y0), .busy(busy0),
    .res_valid(rv0), .res_op(res_op0), .res_x(res_x0), .res_y(res_y0),
    .signature(sig0), .done(done0)
  );

  alu_sweep_driver #(.WIDTH(4), .OP_COUNT(4), .SETTLE(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in1), .b_in(b_in1),
    .a(a1), .b(b1), .opcode(op1), .x(x1), .y(y1), .busy(busy1),
    .res_valid(rv1), .res_op(res_op1), .res_x(res_x1), .res_y(res_y1),
    .signature(sig1), .done(done1)
  );

  int errors = 0;
  int checks = 0;

  // Recorded by run_sweep
  int         vcount, seq_bad, ab_bad, busy_bad, done_cnt, done_edge, max_op;
  logic [7:0] sig_model, sig_acc;
  logic       busy_acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep on dut<sel> at edge 0 and records what happens over edges 1..n_edges.
  task automatic run_sweep(input int sel, input logic [3:0] av, input logic [3:0] bv,
                           input int n_edges, input int stray_edge);
    int   s_cyc, n_ops, k;
    logic c_rv, c_done, c_busy;
    logic [3:0] c_op, c_x, c_a, c_b, c_opcode;
    s_cyc = (sel != 0) ? 4 : 2;
    n_ops = (sel != 0) ? 4 : 16;
    if (sel != 0) begin a_in1 = av; b_in1 = bv; start1 = 1'b1; end
    else          begin a_in0 = av; b_in0 = bv; start0 = 1'b1; end
    tick();
    start0 = 1'b0; start1 = 1'b0;
    a_in0 = ~av; b_in0 = ~bv; a_in1 = ~av; b_in1 = ~bv;
    sig_acc  = (sel != 0) ? sig1 : sig0;
    busy_acc = (sel != 0) ? busy1 : busy0;
    vcount = 0; seq_bad = 0; ab_bad = 0; busy_bad = 0;
    done_cnt = 0; done_edge = -1; max_op = 0; sig_model = 8'h00; k = 0;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == stray_edge) begin
        if (sel != 0) start1 = 1'b1; else start0 = 1'b1;
        a_in0 = 4'b0001; a_in1 = 4'b0001;
      end
      tick();
      start0 = 1'b0; start1 = 1'b0;
      c_rv     = (sel != 0) ? rv1 : rv0;
      c_op     = (sel != 0) ? res_op1 : res_op0;
      c_x      = (sel != 0) ? res_x1 : res_x0;
      c_done   = (sel != 0) ? done1 : done0;
      c_busy   = (sel != 0) ? busy1 : busy0;
      c_a      = (sel != 0) ? a1 : a0;
      c_b      = (sel != 0) ? b1 : b0;
      c_opcode = (sel != 0) ? op1 : op0;
      if (c_rv === 1'b1) begin
        if (c_op !== 4'(k) || c_x !== c_op || e != (k + 1) * s_cyc) seq_bad++;
        sig_model = {sig_model[6:0], sig_model[7]} ^ {4'(k), 4'h0};
        k++;
        vcount++;
      end
      if (c_done === 1'b1) begin
        done_cnt++;
        done_edge = e;
      end
      if (c_a !== av || c_b !== bv) ab_bad++;
      if (int'(c_opcode) > max_op) max_op = int'(c_opcode);
      if (c_busy !== (e < n_ops * s_cyc)) busy_bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b1; start1 = 1'b1;
    a_in0 = 4'hA; b_in0 = 4'h5; a_in1 = 4'hA; b_in1 = 4'h5;
    repeat (3) tick();
    checks++;
    if ({a0, b0, op0, busy0, rv0, res_op0, res_x0, res_y0, sig0, done0} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut0: got %h required 0",
               {a0, b0, op0, busy0, rv0, res_op0, res_x0, res_y0, sig0, done0});
    end
    checks++;
    if ({a1, b1, op1, busy1, rv1, res_op1, res_x1, res_y1, sig1, done1} !== 35'd0) begin
      errors++;
      $display("FAIL reset_dut1: got %h required 0",
               {a1, b1, op1, busy1, rv1, res_op1, res_x1, res_y1, sig1, done1});
    end
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({busy0, busy1, rv0, done0} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got busy0/busy1/rv0/done0=%b required 0000",
               {busy0, busy1, rv0, done0});
    end
  endtask

  task automatic test_default_sweep();
    run_sweep(0, 4'b1100, 4'b1101, 40, -1);
    checks++;
    if (busy_acc !== 1'b1 || sig_acc !== 8'h00) begin
      errors++;
      $display("FAIL dflt_accept: got busy=%b sig=%h required busy=1 sig=00", busy_acc, sig_acc);
    end
    checks++;
    if (ab_bad != 0) begin
      errors++;
      $display("FAIL dflt_ab_hold: got %0d bad cycles required 0", ab_bad);
    end
    checks++;
    if (vcount != 16) begin
      errors++;
      $display("FAIL dflt_pulses: got %0d required 16", vcount);
    end
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("FAIL dflt_sequence: got %0d bad results required 0", seq_bad);
    end
    checks++;
    if (done_cnt != 1 || done_edge != 32) begin
      errors++;
      $display("FAIL dflt_done: got count=%0d edge=%0d required count=1 edge=32", done_cnt, done_edge);
    end
    checks++;
    if (sig0 !== sig_model || sig0 !== 8'hFF) begin
      errors++;
      $display("FAIL dflt_signature: got %h required %h (FF)", sig0, sig_model);
    end
    checks++;
    if (busy_bad != 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL dflt_busy: got %0d bad cycles, final=%b required 0, 0", busy_bad, busy0);
    end
    checks++;
    if (op0 !== 4'd15) begin
      errors++;
      $display("FAIL dflt_final_opcode: got %0d required 15", op0);
    end
  endtask

  task automatic test_start_ignored();
    run_sweep(0, 4'b1100, 4'b1101, 40, 10);
    checks++;
    if (ab_bad != 0 || a0 !== 4'b1100) begin
      errors++;
      $display("FAIL ign_a_hold: got bad=%0d a=%b required 0, 1100", ab_bad, a0);
    end
    checks++;
    if (vcount != 16 || seq_bad != 0) begin
      errors++;
      $display("FAIL ign_sequence: got pulses=%0d bad=%0d required 16, 0", vcount, seq_bad);
    end
    checks++;
    if (done_cnt != 1 || done_edge != 32) begin
      errors++;
      $display("FAIL ign_done: got count=%0d edge=%0d required 1, 32", done_cnt, done_edge);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n_done, n_rv, n_busy;
    a_in0 = 4'b1100; b_in0 = 4'b1101; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    repeat (11) tick();
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy_before: got %b required 1", busy0);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({op0, busy0, sig0, done0, rv0} !== 15'd0) begin
      errors++;
      $display("FAIL mid_reset_state: got op=%0d busy=%b sig=%h done=%b rv=%b required all 0",
               op0, busy0, sig0, done0, rv0);
    end
    rst_n = 1'b1;
    n_done = 0; n_rv = 0; n_busy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done0 === 1'b1) n_done++;
      if (rv0 === 1'b1) n_rv++;
      if (busy0 === 1'b1) n_busy++;
    end
    checks++;
    if (n_done != 0 || n_rv != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL mid_quiet: got done=%0d rv=%0d busy=%0d required 0 0 0", n_done, n_rv, n_busy);
    end
    run_sweep(0, 4'b1100, 4'b1101, 40, -1);
    checks++;
    if (done_edge != 32 || vcount != 16 || seq_bad != 0 || sig0 !== 8'hFF) begin
      errors++;
      $display("FAIL mid_resweep: got edge=%0d pulses=%0d bad=%0d sig=%h required 32 16 0 FF",
               done_edge, vcount, seq_bad, sig0);
    end
  endtask

  task automatic test_settle3();
    run_sweep(1, 4'h3, 4'h5, 24, -1);
    checks++;
    if (vcount != 4 || seq_bad != 0) begin
      errors++;
      $display("FAIL s3_sequence: got pulses=%0d bad=%0d required 4, 0", vcount, seq_bad);
    end
    checks++;
    if (done_cnt != 1 || done_edge != 16) begin
      errors++;
      $display("FAIL s3_done: got count=%0d edge=%0d required 1, 16", done_cnt, done_edge);
    end
    checks++;
    if (max_op > 3) begin
      errors++;
      $display("FAIL s3_opcode_max: got %0d required <=3", max_op);
    end
    checks++;
    if (sig1 !== sig_model || sig1 !== 8'h30) begin
      errors++;
      $display("FAIL s3_signature: got %h required %h (30)", sig1, sig_model);
    end
    checks++;
    if (busy_bad != 0 || ab_bad != 0) begin
      errors++;
      $display("FAIL s3_busy_ab: got busy_bad=%0d ab_bad=%0d required 0, 0", busy_bad, ab_bad);
    end
  endtask

  task automatic test_back_to_back();
    // First sweep stops right after the DONE cycle, so the next start lands in the first IDLE cycle
    run_sweep(0, 4'b1100, 4'b1101, 33, -1);
    checks++;
    if (done_edge != 32 || sig0 !== 8'hFF || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got edge=%0d sig=%h busy=%b required 32 FF 0", done_edge, sig0, busy0);
    end
    run_sweep(0, 4'b0110, 4'b1001, 40, -1);
    checks++;
    if (busy_acc !== 1'b1 || sig_acc !== 8'h00) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b sig=%h required 1, 00", busy_acc, sig_acc);
    end
    checks++;
    if (ab_bad != 0 || done_cnt != 1 || done_edge != 32 || vcount != 16 || seq_bad != 0) begin
      errors++;
      $display("FAIL b2b_second: got ab_bad=%0d done=%0d edge=%0d pulses=%0d bad=%0d required 0 1 32 16 0",
               ab_bad, done_cnt, done_edge, vcount, seq_bad);
    end
  endtask

  initial begin
    rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0;
    a_in0 = 4'h0; b_in0 = 4'h0; a_in1 = 4'h0; b_in1 = 4'h0;
    test_reset();
    test_default_sweep();
    test_start_ignored();
    test_reset_mid_sweep();
    test_settle3();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
